// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite response codes and the configuration sequencer state type.
package axilite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_RESP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/axilite_cfg_sequencer.sv
// Table-driven AXI4-Lite write master: walks (address, data) entries and
// writes each one, stopping at the last entry, on an error response or on
// a response timeout.
module axilite_cfg_sequencer
   import axilite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned IDX_WIDTH      = 6,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic                    err_timeout,
   output logic [1:0]              err_resp,
   output logic [IDX_WIDTH-1:0]    err_index,
   output logic [IDX_WIDTH-1:0]    tbl_index,
   input  logic [ADDR_WIDTH-1:0]   tbl_addr,
   input  logic [DATA_WIDTH-1:0]   tbl_data,
   input  logic                    tbl_last,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [2:0]              awprot,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned TMR_WIDTH  = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_MAX  = '1;

   state_t                  state, state_d;
   logic [IDX_WIDTH-1:0]    idx_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [DATA_WIDTH-1:0]   data_d;
   logic                    last_q, last_d;
   logic [TMR_WIDTH-1:0]    tmr, tmr_d;
   logic                    awvalid_d, wvalid_d, bready_d;
   logic                    busy_d, done_d, err_d, err_timeout_d;
   logic [1:0]              err_resp_d;
   logic [IDX_WIDTH-1:0]    err_index_d;
   logic                    timeout_hit;

   assign awprot = 3'b000;
   assign wstrb  = {STRB_WIDTH{1'b1}};

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d       = state;
      idx_d         = tbl_index;
      addr_d        = awaddr;
      data_d        = wdata;
      last_d        = last_q;
      tmr_d         = tmr;
      awvalid_d     = awvalid;
      wvalid_d      = wvalid;
      bready_d      = bready;
      busy_d        = busy;
      done_d        = done;
      err_d         = err;
      err_timeout_d = err_timeout;
      err_resp_d    = err_resp;
      err_index_d   = err_index;
      timeout_hit   = 1'b0;

      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d       = ST_LOAD;
               idx_d         = '0;
               err_d         = 1'b0;
               err_timeout_d = 1'b0;
               err_resp_d    = RESP_OKAY;
               err_index_d   = '0;
               done_d        = 1'b0;
               busy_d        = 1'b1;
            end
         end
         ST_LOAD: begin
            addr_d    = tbl_addr;
            data_d    = tbl_data;
            last_d    = tbl_last;
            tmr_d     = '0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_ISSUE;
         end
         ST_ISSUE: begin
            tmr_d = tmr + TMR_WIDTH'(1);
            if (awvalid && awready) awvalid_d = 1'b0;
            if (wvalid && wready)   wvalid_d  = 1'b0;
            if (tmr == TMR_LAST) begin
               timeout_hit = 1'b1;
            end else if (!awvalid_d && !wvalid_d) begin
               state_d  = ST_RESP;
               bready_d = 1'b1;
            end
         end
         ST_RESP: begin
            tmr_d = tmr + TMR_WIDTH'(1);
            if (bvalid) begin
               bready_d = 1'b0;
               if (bresp != RESP_OKAY) begin
                  err_d       = 1'b1;
                  err_resp_d  = bresp;
                  err_index_d = tbl_index;
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = ST_DONE;
               end else if (last_q || (tbl_index == IDX_MAX)) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = tbl_index + IDX_WIDTH'(1);
                  state_d = ST_LOAD;
               end
            end else if (tmr == TMR_LAST) begin
               timeout_hit = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Response timeout abandons the current write and ends the sequence.
      if (timeout_hit) begin
         state_d       = ST_DONE;
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         busy_d        = 1'b0;
         done_d        = 1'b1;
         err_d         = 1'b1;
         err_timeout_d = 1'b1;
         err_index_d   = tbl_index;
      end
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= ST_IDLE;
         tbl_index   <= '0;
         awaddr      <= '0;
         wdata       <= '0;
         last_q      <= 1'b0;
         tmr         <= '0;
         awvalid     <= 1'b0;
         wvalid      <= 1'b0;
         bready      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_timeout <= 1'b0;
         err_resp    <= 2'b00;
         err_index   <= '0;
      end else begin
         state       <= state_d;
         tbl_index   <= idx_d;
         awaddr      <= addr_d;
         wdata       <= data_d;
         last_q      <= last_d;
         tmr         <= tmr_d;
         awvalid     <= awvalid_d;
         wvalid      <= wvalid_d;
         bready      <= bready_d;
         busy        <= busy_d;
         done        <= done_d;
         err         <= err_d;
         err_timeout <= err_timeout_d;
         err_resp    <= err_resp_d;
         err_index   <= err_index_d;
      end
   end

endmodule

// File: tb/tb_axilite_cfg_sequencer.sv
// Self-checking bench for axilite_cfg_sequencer: AXI-Lite slave with
// programmable delays and responses, checked against an outcome model.
`timescale 1ns/1ps
module tb_axilite_cfg_sequencer;
   import axilite_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 2;
   localparam int unsigned TO = 16;
   localparam int N      = 4;
   localparam int NO_ERR = 99;

   logic          aclk = 1'b0;
   logic          areset, start;
   logic          busy, done, err, err_timeout;
   logic [1:0]    err_resp;
   logic [IW-1:0] err_index, tbl_index;
   logic [AW-1:0] tbl_addr, awaddr;
   logic [DW-1:0] tbl_data, wdata;
   logic          tbl_last;
   logic [2:0]    awprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic [DW/8-1:0] wstrb;
   logic [1:0]    bresp;

   always #5 aclk = ~aclk;

   axilite_cfg_sequencer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .aclk(aclk), .areset(areset), .start(start), .busy(busy), .done(done),
      .err(err), .err_timeout(err_timeout), .err_resp(err_resp),
      .err_index(err_index), .tbl_index(tbl_index), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .tbl_last(tbl_last), .awaddr(awaddr),
      .awprot(awprot), .awvalid(awvalid), .awready(awready), .wdata(wdata),
      .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
      .bvalid(bvalid), .bready(bready)
   );

   // Configuration table seen by the DUT.
   logic [AW-1:0] tb_addr [N];
   logic [DW-1:0] tb_data [N];
   int            last_idx;
   assign tbl_addr = tb_addr[tbl_index];
   assign tbl_data = tb_data[tbl_index];
   assign tbl_last = (int'(tbl_index) == last_idx);

   // Scenario knobs.
   int         cfg_err_at, cfg_fa, cfg_fw, cfg_fb;
   logic [1:0] cfg_err_val;
   bit         cfg_b_en, cfg_rnd, cfg_busy_start, cfg_tmo_probe;

   // Slave bookkeeping.
   int aw_dly, w_dly, b_dly, aw_seen, w_seen, b_seen, aw_cnt, w_cnt, b_cnt;
   logic [AW-1:0] wr_addr [$];
   logic [DW-1:0] wr_data [$];

   int n_err = 0;
   int n_chk = 0;
   int cyc, done_cyc, aw_hi, w_hi, stab_bad;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input int fixed);
      return cfg_rnd ? int'($urandom_range(0, 3)) : fixed;
   endfunction

   function automatic logic [11:0] out_bits();
      return {|awaddr, |wdata, busy, done, err, err_timeout, |err_resp,
              |err_index, |tbl_index, awvalid, wvalid, bready};
   endfunction

   task automatic slave_clear();
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      aw_seen = 0; w_seen = 0; b_seen = 0;
      aw_dly = pick(cfg_fa); w_dly = pick(cfg_fw); b_dly = pick(cfg_fb);
      wr_addr.delete(); wr_data.delete();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
   endtask

   // Slave decisions for the current cycle; handshakes complete at the next edge.
   task automatic slave_eval();
      bvalid = 1'b0;
      bresp  = RESP_OKAY;
      if (cfg_b_en && aw_cnt > b_cnt && w_cnt > b_cnt) begin
         if (b_seen >= b_dly) begin
            bvalid = 1'b1;
            bresp  = (b_cnt == cfg_err_at) ? cfg_err_val : RESP_OKAY;
            if (bready) begin b_cnt++; b_seen = 0; b_dly = pick(cfg_fb); end
         end else b_seen++;
      end else if (cfg_b_en && !bready) begin
         bvalid = ($urandom_range(0, 1) == 1);
         bresp  = RESP_DECERR;
      end
      awready = 1'b0;
      if (awvalid) begin
         if (aw_seen >= aw_dly) begin
            awready = 1'b1; wr_addr.push_back(awaddr); aw_cnt++;
            aw_seen = 0; aw_dly = pick(cfg_fa);
         end else aw_seen++;
      end
      wready = 1'b0;
      if (wvalid) begin
         if (w_seen >= w_dly) begin
            wready = 1'b1; wr_data.push_back(wdata); w_cnt++;
            w_seen = 0; w_dly = pick(cfg_fw);
         end else w_seen++;
      end
   endtask

   task automatic step();
      @(negedge aclk);
      cyc++;
      slave_eval();
   endtask

   // One full sequence from start to done, then outcome checks against the model.
   task automatic run_seq(input string name);
      int stop, x_n, x_idx, bad;
      logic x_err, x_to;
      logic [1:0] x_resp;
      slave_clear();
      aw_hi = 0; w_hi = 0; stab_bad = 0;
      @(negedge aclk);
      cyc = 0; start = 1'b1;
      slave_eval();
      do begin
         step();
         start = cfg_busy_start && busy && ($urandom_range(0, 3) == 0);
         if (cyc == 1) chk({name, "_busy_t1"}, 64'(busy), 64'd1);
         if (cyc == 2) chk({name, "_valid_t2"}, 64'({awvalid, wvalid}), 64'd3);
         if (awvalid) begin aw_hi++; if (awaddr !== tb_addr[tbl_index]) stab_bad++; end
         if (wvalid)  begin w_hi++;  if (wdata !== tb_data[tbl_index])  stab_bad++; end
         if (cfg_tmo_probe && cyc == int'(TO) + 1)
            chk({name, "_pre_timeout"}, 64'({done, bready}), 64'd1);
         if (cfg_tmo_probe && cyc == int'(TO) + 2)
            chk({name, "_at_timeout"}, 64'({done, err_timeout, bready}), 64'd6);
      end while (!done && cyc < 300);
      start = 1'b0;
      done_cyc = cyc;

      // Expected outcome from the table, response plan and B availability.
      stop = (last_idx < N) ? last_idx : N - 1;
      if (!cfg_b_en) begin
         x_n = 1; x_err = 1'b1; x_to = 1'b1; x_resp = RESP_OKAY; x_idx = 0;
      end else if (cfg_err_at <= stop) begin
         x_n = cfg_err_at + 1; x_err = 1'b1; x_to = 1'b0; x_resp = cfg_err_val; x_idx = cfg_err_at;
      end else begin
         x_n = stop + 1; x_err = 1'b0; x_to = 1'b0; x_resp = RESP_OKAY; x_idx = 0;
      end

      chk({name, "_done"},        64'(done), 64'd1);
      chk({name, "_busy_end"},    64'(busy), 64'd0);
      chk({name, "_bready_end"},  64'(bready), 64'd0);
      chk({name, "_err"},         64'(err), 64'(x_err));
      chk({name, "_err_timeout"}, 64'(err_timeout), 64'(x_to));
      chk({name, "_err_resp"},    64'(err_resp), 64'(x_resp));
      chk({name, "_err_index"},   64'(err_index), 64'(x_idx));
      chk({name, "_n_writes"},    64'(wr_addr.size()), 64'(x_n));
      bad = 0;
      for (int i = 0; i < x_n; i++) begin
         if (i >= wr_addr.size() || i >= wr_data.size()) bad++;
         else if (wr_addr[i] !== tb_addr[i] || wr_data[i] !== tb_data[i]) bad++;
      end
      chk({name, "_write_seq"},   64'(bad), 64'd0);
      chk({name, "_stable"},      64'(stab_bad), 64'd0);
   endtask

   initial begin
      areset = 1'b1; start = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
      last_idx = N; cfg_err_at = NO_ERR; cfg_err_val = RESP_OKAY;
      cfg_fa = 0; cfg_fw = 0; cfg_fb = 0;
      cfg_b_en = 1'b1; cfg_rnd = 1'b0; cfg_busy_start = 1'b0; cfg_tmo_probe = 1'b0;
      for (int i = 0; i < N; i++) begin tb_addr[i] = AW'(4 * i); tb_data[i] = DW'(17 * (i + 1)); end
      repeat (3) @(negedge aclk);
      chk("reset_outputs", 64'(out_bits()), 64'd0);
      chk("wstrb", 64'(wstrb), 64'hf);
      chk("awprot", 64'(awprot), 64'd0);
      areset = 1'b0;

      // Three entries, zero-wait slave.
      last_idx = 2;
      run_seq("zero_wait");
      chk("zero_wait_done_cycle", 64'(done_cyc), 64'd10);

      // AW accepted 3 cycles late while W is accepted at once.
      last_idx = 0; cfg_fa = 3; cfg_fw = 0;
      run_seq("aw_delay");
      chk("aw_delay_awvalid_cycles", 64'(aw_hi), 64'd4);
      chk("aw_delay_wvalid_cycles",  64'(w_hi), 64'd1);
      cfg_fa = 0;

      // Slave error on entry 1.
      last_idx = 2; cfg_err_at = 1; cfg_err_val = RESP_SLVERR;
      run_seq("slverr");
      cfg_err_at = NO_ERR;

      // No write response ever.
      cfg_b_en = 1'b0; cfg_tmo_probe = 1'b1;
      run_seq("timeout");
      chk("timeout_done_cycle", 64'(done_cyc), 64'(TO + 2));
      repeat (3) step();
      chk("timeout_bready_after", 64'(bready), 64'd0);
      cfg_b_en = 1'b1; cfg_tmo_probe = 1'b0;

      // Reset while a write is outstanding.
      last_idx = 3; cfg_fa = 20; cfg_fw = 20;
      slave_clear();
      @(negedge aclk);
      cyc = 0; start = 1'b1;
      slave_eval();
      step(); start = 1'b0;
      step(); step();
      chk("reset_mid_awvalid_before", 64'(awvalid), 64'd1);
      areset = 1'b1;
      step();
      chk("reset_mid_outputs", 64'(out_bits()), 64'd0);
      areset = 1'b0;
      cfg_fa = 0; cfg_fw = 0;
      run_seq("after_reset");

      // Never-last table runs to the final index; start pulses while busy.
      last_idx = N; cfg_busy_start = 1'b1;
      run_seq("no_last");

      // Randomised tables, delays, responses and timeouts.
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < N; i++) begin tb_addr[i] = $urandom; tb_data[i] = $urandom; end
         last_idx    = int'($urandom_range(0, N));
         cfg_err_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : NO_ERR;
         cfg_err_val = 2'($urandom_range(1, 3));
         cfg_b_en    = ($urandom_range(0, 7) != 0);
         cfg_rnd     = 1'b1;
         cfg_busy_start = 1'b1;
         run_seq("random");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
